alu_seq: RTL

Registered, handshaked successor to the combinational parametrised ALU. It accepts one operation per transfer on a valid/ready input channel and returns a result on a valid/ready output channel. The result carries a registered flag set (Z, C, N, V, err). The block adds an optional multi-cycle shift-add multiplier. It sits between the operand/opcode source (switch/register front end) and the display/LED result path.

---
 rtl/alu_seq.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a result/flag output buffer.
//
// One operation is accepted per input transfer (in_valid & in_ready) and its
// result is returned through a single-entry output buffer on a valid/ready
// channel. Single-cycle ops appear in the buffer on the transfer edge itself.
// MUL (opcode 1010) runs a shift-add multiplier: busy for WIDTH cycles, then
// the product is written into the buffer.
//
// Build option: define ALU_SEQ_MUL_EN to compile in the multiplier. Without
// it, opcode 1010 is illegal, there is no multiplier logic, and busy is 0.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand channel handshake (in_ready combinational)
//   a, b, op, flag_in     operands, opcode, carry-in / operand select / fill
//   out_valid / out_ready result channel handshake
//   result, result_hi     result (MUL: low / high product halves)
//   z, c, n, v, err       zero, carry/borrow, sign, overflow, illegal opcode
//   busy                  multiplier iterating
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             flag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             err,
  output logic             busy
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_INC = 4'b0011,
    OP_DEC = 4'b0100, OP_NOT = 4'b0101, OP_SUB = 4'b0110, OP_XOR = 4'b0111,
    OP_SHR = 4'b1000, OP_SHL = 4'b1001, OP_MUL = 4'b1010
  } op_e;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_e;

  localparam logic [WIDTH-1:0] WB = WIDTH'(WIDTH);

  state_e state, state_next;

  logic               in_fire, is_mul, mul_start, run_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_fire   = in_valid & in_ready;
  assign mul_start = in_fire & is_mul;

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH-1:0]   alu_res, sel;
  logic               alu_c, alu_v, alu_err;
  logic [WIDTH:0]     sum, diff, shr_c, shl_c;
  logic [2*WIDTH-1:0] shr_ext, shl_ext;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would infer a latch.
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = '0;
    diff    = '0;
    shr_ext = '0;
    shl_ext = '0;
    shr_c   = '0;
    shl_c   = '0;
    sel     = flag_in ? b : a;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~sel;
      OP_ADD: begin
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flag_in};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, flag_in};
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        alu_res = sel + WIDTH'(1);
        alu_c   = &sel;
      end
      OP_DEC: begin
        alu_res = sel - WIDTH'(1);
        alu_c   = ~|sel;
      end
      // Shifting a double-width {fill, a} pulls flag_in into vacated bits; a
      // spare bit beside a catches the last bit shifted out. Shifts of WIDTH
      // or more give all-fill with c=0, so they bypass the shifter.
      OP_SHR: begin
        if (b >= WB) begin
          alu_res = {WIDTH{flag_in}};
        end else begin
          shr_ext = {{WIDTH{flag_in}}, a} >> b;
          shr_c   = {a, 1'b0} >> b;
          alu_res = shr_ext[WIDTH-1:0];
          alu_c   = shr_c[0];
        end
      end
      OP_SHL: begin
        if (b >= WB) begin
          alu_res = {WIDTH{flag_in}};
        end else begin
          shl_ext = {a, {WIDTH{flag_in}}} << b;
          shl_c   = {1'b0, a} << b;
          alu_res = shl_ext[2*WIDTH-1:WIDTH];
          alu_c   = shl_c[WIDTH];
        end
      end
      // Illegal opcodes; MUL lands here too but, when the multiplier is
      // built, its result comes from the multiplier path instead.
      default: alu_err = 1'b1;
    endcase
  end

  // ---------------- shift-add multiplier ----------------
`ifdef ALU_SEQ_MUL_EN
  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_RUN = CW'(WIDTH - 2);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     psum;
  logic [CW-1:0]      step;

  assign is_mul = (op == OP_MUL);

  // prod holds {partial sum, remaining multiplier bits}: add the multiplicand
  // into the top half when the current multiplier bit is set, then shift the
  // whole register right. After WIDTH steps it is the full product.
  assign psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {psum, prod[WIDTH-1:1]};
  assign mul_prod  = prod_next;

  // WIDTH-1 steps happen in MUL_RUN; the last step's result goes straight
  // into the output buffer from DONE.
  assign run_last = (state == MUL_RUN) && (step == LAST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      prod  <= '0;
      step  <= '0;
    end else if (mul_start) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      step  <= '0;
    end else if (state == MUL_RUN) begin
      prod <= prod_next;
      step <= step + CW'(1);
    end
  end
`else
  assign is_mul   = 1'b0;
  assign run_last = 1'b0;
  assign mul_prod = '0;
`endif

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL_RUN;
      MUL_RUN: if (run_last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
`ifdef ALU_SEQ_MUL_EN
    busy = (state != IDLE);
`else
    busy = 1'b0;
`endif
  end

  // ---------------- output buffer ----------------
  // Loading a new result takes priority over draining, so a simultaneous
  // output and input transfer keeps out_valid high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      err       <= 1'b0;
    end else if (in_fire && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      result_hi <= '0;
      z         <= ~|alu_res;
      c         <= alu_c;
      n         <= alu_res[WIDTH-1];
      v         <= alu_v;
      err       <= alu_err;
    end else if (state == DONE) begin
      out_valid <= 1'b1;
      result    <= mul_prod[WIDTH-1:0];
      result_hi <= mul_prod[2*WIDTH-1:WIDTH];
      z         <= ~|mul_prod;
      c         <= |mul_prod[2*WIDTH-1:WIDTH];
      n         <= mul_prod[WIDTH-1];
      v         <= 1'b0;
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
